gray_seq_ctrl: RTL
==================

# gray_seq_ctrl

Command-driven sequencer for a gray-code counter. It accepts a step-count and step-rate command over a valid/ready handshake, advances an internal binary counter once per programmed interval, and presents the count in gray code. It supports pause, abort and an optional clear-on-start, and signals completion with a one-cycle pulse. It sits between the control logic (FSM, button/debounce front end) and the display/encoder logic that consumes `gray_o`.

## Interface
- `WIDTH`, default 4: counter width in bits; the count wraps at 2^WIDTH-1 -> 0.
- `LEN_W`, default 8: width of the step-count field.
- `DIV_W`, default 8: width of the prescaler field.

- `clk_i`, in, 1: single clock, rising edge.
- `rst_n_i`, in, 1: asynchronous active-low reset.
- `cmd_valid_i`, in, 1: command present.
- `cmd_ready_o`, out, 1: high exactly when state is IDLE.
- `cmd_len_i`, in, LEN_W: number of steps to run (0 is legal).
- `cmd_div_i`, in, DIV_W: clock cycles per step, minus 1.
- `cmd_clr_i`, in, 1: clear the count to 0 on accept.
- `pause_i`, in, 1: level; holds the count and prescaler.
- `abort_i`, in, 1: level; terminates the run early.
- `busy_o`, out, 1: state is RUN or PAUSE.
- `paused_o`, out, 1: state is PAUSE.
- `step_o`, out, 1: one-cycle pulse on each count advance.
- `done_o`, out, 1: one-cycle pulse at the end of a command.
- `aborted_o`, out, 1: qualifies `done_o`; high if the run ended by abort.
- `gray_o`, out, WIDTH: `bin ^ (bin >> 1)` of the registered binary count.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. Reset -> IDLE.
- **Accept:** fires on `cmd_valid_i && cmd_ready_o`. The block latches `len` and `div`, and sets prescaler `pre = 0`.
  - If `cmd_clr_i=1`, `bin = 0`.
  - If `len == 0`, go to DONE; otherwise go to RUN.
- **RUN:** per-cycle priority is abort > pause > step.
  - `abort_i=1`: go to DONE with `aborted` set. No step occurs that cycle.
  - `pause_i=1`: go to PAUSE. `pre` and `bin` are held.
  - Otherwise, if `pre == div`:
    - `bin` increments, wrapping from 2^WIDTH-1 to 0.
    - `step_o` pulses, `pre` resets to 0, and `len` decrements.
    - If `len` was 1, go to DONE.
  - Otherwise `pre` increments.
- **PAUSE:**
  - `abort_i=1`: go to DONE with `aborted` set.
  - `pause_i=0`: return to RUN. `pre` resumes from its held value.
- **DONE:** `done_o=1` and `aborted_o` reflects how the run ended, both for exactly one cycle. Next state is IDLE, where `aborted` clears.
- **Command inputs:** ignored outside the accept cycle. Input changes during a run have no effect.
- **Count persistence:** `bin` persists across commands unless `cmd_clr_i` is set.
- **Pause/abort in IDLE or DONE:** no effect.

## Timing
- **Reset values:**
  - `bin=0`, so `gray_o=0`.
  - `step_o`, `done_o`, `aborted_o`, `busy_o` and `paused_o` are all 0.
  - `cmd_ready_o=1`, both during and after reset.
- **Step timing:** with accept on edge k, step n occurs at edge k + n·(div+1), assuming no pause. `gray_o` updates on the same edge as `step_o`.
- **Completion timing:**
  - `done_o` is high in the cycle following the last-step edge.
  - `cmd_ready_o` returns 1 one cycle after `done_o`.
  - Back-to-back commands are therefore separated by at least 2 cycles.
- **Zero-length command:** accept at edge k gives `done_o` high for the cycle after k, with no `step_o` and `aborted_o=0`.
- **Pause latency:** each cycle of `pause_i` high delays all remaining steps by exactly one cycle (the transition cycle is included).
- **Reset mid-run:** immediately returns to IDLE with `bin=0`. No `done_o` is produced.
- **Abort on a terminal-prescaler cycle:** abort wins. No step occurs and `len` is unchanged.

## Structure
- **Package `gray_ctrl_pkg`:**
  - state enum `{IDLE, RUN, PAUSE, DONE}`
  - default WIDTH, LEN_W and DIV_W constants
  - gray conversion function `bin2gray`
- **Sub-module `gray_step_core`:**
  - Ports: `clk_i`, `rst_n_i`, `en_i`, `clr_i`, `gray_o`, `bin_o`.
  - A WIDTH-bit wrap counter plus the gray output.
- **`gray_seq_ctrl`:** contains the FSM, prescaler, remaining-step counter and handshake logic, and drives `en_i`/`clr_i` of the core.

## Test plan
- **Reset mid-run:** reset, then assert `rst_n_i=0` mid-run -> all outputs at reset values, `cmd_ready_o=1`, `gray_o=0`.
- **Basic run:** `len=5`, `div=0`, `clr=1` -> `step_o` on 5 consecutive edges. `gray_o` goes 0001, 0011, 0010, 0110, 0111. `done_o` pulses once with `aborted_o=0`.
- **Wrap with prescale:** `len=17`, `div=2`, starting from `bin=0` -> steps every 3 cycles, `gray_o` wraps 1000 -> 0000, final `gray_o=0001`, `done_o` at accept+52 cycles.
- **Pause:** `len=4`, `div=1`, with `pause_i` high for 3 cycles after step 2 -> `paused_o` high, `gray_o` frozen, remaining steps delayed by 3 cycles, total step count 4.
- **Abort precedence:** `len=10`, `div=0`, with `abort_i` asserted on the cycle when step 3 would occur -> exactly 2 steps, `done_o` and `aborted_o` pulse together, `cmd_ready_o` returns after 1 cycle.
- **Edge cases:**
  - `len=0` -> `done_o` with no step.
  - `cmd_valid_i` held high during a run -> ignored until `cmd_ready_o` is high.
  - A second command with `clr=0` continues from the previous count.

Source files
------------

// File: rtl/gray_ctrl_pkg.sv
// gray_ctrl_pkg: shared types and constants for the gray-code sequencer.
//   state_t   - sequencer FSM states
//   DEF_*     - default parameter values for counter, step-count and prescaler widths
//   bin2gray  - binary to reflected gray conversion (up to 32 bits)
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_DIV_W = 8;

    // Callers zero-extend into 32 bits and truncate the result back to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_core.sv
// gray_step_core: WIDTH-bit wrapping binary counter with gray-coded view.
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset, clears the count
//   en_i    - advance the count by one (wraps 2^WIDTH-1 -> 0)
//   clr_i   - synchronous clear, wins over en_i
//   gray_o  - gray code of the registered count
//   bin_o   - registered binary count
module gray_step_core
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] bin_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bin_q <= '0;
        end else if (clr_i) begin
            bin_q <= '0;
        end else if (en_i) begin
            bin_q <= bin_q + WIDTH'(1);
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = WIDTH'(bin2gray(32'(bin_q)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: command-driven sequencer for a gray-code counter.
//   clk_i, rst_n_i          - clock and asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o - command handshake; ready is high only in IDLE
//   cmd_len_i               - number of steps to run (0 completes immediately)
//   cmd_div_i               - clock cycles per step minus one
//   cmd_clr_i               - clear the count to 0 on accept
//   pause_i, abort_i        - run-time level controls (abort has priority)
//   busy_o, paused_o        - RUN/PAUSE and PAUSE state indications
//   step_o                  - one-cycle pulse coincident with each count advance
//   done_o, aborted_o       - one-cycle completion pulse and its abort qualifier
//   gray_o                  - gray code of the registered binary count
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [DIV_W-1:0] cmd_div_i,
    input  logic             cmd_clr_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             paused_o,
    output logic             step_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [WIDTH-1:0] gray_o
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             ab_q, ab_d;
    logic             step_q;
    logic             core_en, core_clr;
    logic [WIDTH-1:0] core_bin, core_gray;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            div_q   <= '0;
            pre_q   <= '0;
            ab_q    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            ab_q    <= ab_d;
            step_q  <= core_en;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        div_d    = div_q;
        pre_d    = pre_q;
        ab_d     = ab_q;
        core_en  = 1'b0;
        core_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                ab_d = 1'b0;
                if (cmd_valid_i) begin
                    len_d    = cmd_len_i;
                    div_d    = cmd_div_i;
                    pre_d    = '0;
                    core_clr = cmd_clr_i;
                    state_d  = (cmd_len_i == '0) ? DONE : RUN;
                end
            end
            // RUN and PAUSE share one arm: the cycle that leaves PAUSE also
            // makes progress, so each cycle of pause_i high costs exactly one
            // cycle of delay, including the cycle that entered PAUSE.
            RUN, PAUSE: begin
                if (abort_i) begin
                    ab_d    = 1'b1;
                    state_d = DONE;
                end else if (pause_i) begin
                    state_d = PAUSE;
                end else begin
                    state_d = RUN;
                    if (pre_q == div_q) begin
                        core_en = 1'b1;
                        pre_d   = '0;
                        len_d   = len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        pre_d = pre_q + DIV_W'(1);
                    end
                end
            end
            DONE: begin
                ab_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    gray_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (core_en),
        .clr_i   (core_clr),
        .gray_o  (core_gray),
        .bin_o   (core_bin)
    );

    // The core's gray view must always track its binary count.
    gray_consistent_a : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        core_gray == WIDTH'(bin2gray(32'(core_bin))));

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == RUN) || (state_q == PAUSE);
    assign paused_o    = (state_q == PAUSE);
    assign step_o      = step_q;
    assign done_o      = (state_q == DONE);
    assign aborted_o   = (state_q == DONE) && ab_q;
    assign gray_o      = core_gray;

endmodule
